// File: rtl/alu_pkg.sv
// Shared definitions for the ALU command path: op codes, sequencer states
// and the default register-index width.
package alu_pkg;

    localparam int DATA_W = 8;
    localparam int OP_W   = 4;
    localparam int REG_AW = 2;

    localparam logic [OP_W-1:0] OP_ADD   = 4'd0;
    localparam logic [OP_W-1:0] OP_ADC   = 4'd1;
    localparam logic [OP_W-1:0] OP_SUB   = 4'd2;
    localparam logic [OP_W-1:0] OP_SBC   = 4'd3;
    localparam logic [OP_W-1:0] OP_OR    = 4'd4;
    localparam logic [OP_W-1:0] OP_AND   = 4'd5;
    localparam logic [OP_W-1:0] OP_NOT   = 4'd6;
    localparam logic [OP_W-1:0] OP_XOR   = 4'd7;
    localparam logic [OP_W-1:0] OP_PASSA = 4'd8;
    localparam logic [OP_W-1:0] OP_PASSB = 4'd9;
    localparam logic [OP_W-1:0] OP_NEG   = 4'd10;
    localparam logic [OP_W-1:0] OP_CMP   = 4'd11;
    localparam logic [OP_W-1:0] OP_SHL   = 4'd12;
    localparam logic [OP_W-1:0] OP_SHR   = 4'd13;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ISSUE  = 2'd1,
        ST_COMMIT = 2'd2
    } seq_state_t;

endpackage

// File: rtl/alu_regfile.sv
// NREGS x 8 register file: two operand read ports, one debug read port,
// one synchronous write port, cleared by synchronous reset.
module alu_regfile
    import alu_pkg::*;
#(
    parameter  int NREGS = 4,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [AW-1:0]     i_ra_addr,
    output logic [DATA_W-1:0] o_ra_data,
    input  logic [AW-1:0]     i_rb_addr,
    output logic [DATA_W-1:0] o_rb_data,
    input  logic [AW-1:0]     i_rd_addr,
    output logic [DATA_W-1:0] o_rd_data,
    input  logic              i_we,
    input  logic [AW-1:0]     i_wa,
    input  logic [DATA_W-1:0] i_wd
);

    logic [DATA_W-1:0] r_mem [NREGS];

    // NOTE: this array is reset on purpose (registers must read 0x00 after
    // reset), so it maps to flops; a large array would normally stay unreset RAM.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we) begin
            r_mem[i_wa] <= i_wd;
        end
    end

    assign o_ra_data = r_mem[i_ra_addr];
    assign o_rb_data = r_mem[i_rb_addr];
    assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/alu_sequencer.sv
// Command-side driver of the 8-bit ALU: accept, issue registered operands,
// then commit the ALU result into the register file and flags.
module alu_sequencer
    import alu_pkg::*;
#(
    parameter  int         NREGS       = 4,
    parameter  logic [1:0] RESET_FLAGS = 2'b00,
    localparam int         AW          = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [OP_W-1:0]   cmd_op,
    input  logic [AW-1:0]     cmd_dst,
    input  logic [AW-1:0]     cmd_srca,
    input  logic [AW-1:0]     cmd_srcb,
    input  logic              cmd_use_imm,
    input  logic [DATA_W-1:0] cmd_imm,
    input  logic              cmd_wreg,
    input  logic              cmd_wflags,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic              alu_carry,
    output logic [OP_W-1:0]   alu_op,
    input  logic [DATA_W-1:0] alu_c,
    input  logic              alu_carry_out,
    input  logic              alu_zero,
    output logic              res_valid,
    output logic [DATA_W-1:0] res_data,
    output logic              flag_carry,
    output logic              flag_zero,
    input  logic [AW-1:0]     rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    seq_state_t        r_state;
    seq_state_t        w_next_state;
    logic              w_ready;
    logic              w_accept;
    logic              w_commit;

    logic [AW-1:0]     r_dst;
    logic              r_wreg;
    logic              r_wflags;
    logic [DATA_W-1:0] r_alu_a;
    logic [DATA_W-1:0] r_alu_b;
    logic              r_alu_carry;
    logic [OP_W-1:0]   r_alu_op;
    logic              r_res_valid;
    logic [DATA_W-1:0] r_res_data;
    logic              r_flag_carry;
    logic              r_flag_zero;

    logic [DATA_W-1:0] w_rd_a;
    logic [DATA_W-1:0] w_rd_b;

    alu_regfile #(
        .NREGS (NREGS)
    ) u_regfile (
        .clk       (clk),
        .reset     (reset),
        .i_ra_addr (cmd_srca),
        .o_ra_data (w_rd_a),
        .i_rb_addr (cmd_srcb),
        .o_rb_data (w_rd_b),
        .i_rd_addr (rd_addr),
        .o_rd_data (rd_data),
        .i_we      (w_commit & r_wreg),
        .i_wa      (r_dst),
        .i_wd      (alu_c)
    );

    // NOTE: every signal gets a default before the case, so no path leaves
    // one unassigned and no latch is inferred.
    always_comb begin
        w_next_state = r_state;
        w_ready      = 1'b0;
        w_accept     = 1'b0;
        w_commit     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_ready = 1'b1;
                if (cmd_valid) begin
                    w_accept     = 1'b1;
                    w_next_state = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                w_next_state = ST_COMMIT;
            end
            ST_COMMIT: begin
                w_commit     = 1'b1;
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // NOTE: state uses non-blocking assignments so every flop samples values
    // from before the edge, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_dst        <= '0;
            r_wreg       <= 1'b0;
            r_wflags     <= 1'b0;
            r_alu_a      <= '0;
            r_alu_b      <= '0;
            r_alu_carry  <= 1'b0;
            r_alu_op     <= '0;
            r_res_valid  <= 1'b0;
            r_res_data   <= '0;
            r_flag_carry <= RESET_FLAGS[1];
            r_flag_zero  <= RESET_FLAGS[0];
        end else begin
            r_state     <= w_next_state;
            r_res_valid <= w_commit;
            if (w_accept) begin
                r_dst       <= cmd_dst;
                r_wreg      <= cmd_wreg;
                r_wflags    <= cmd_wflags;
                r_alu_a     <= w_rd_a;
                r_alu_b     <= cmd_use_imm ? cmd_imm : w_rd_b;
                r_alu_op    <= cmd_op;
                r_alu_carry <= r_flag_carry;
            end
            if (w_commit) begin
                r_res_data <= alu_c;
                if (r_wflags) begin
                    r_flag_carry <= alu_carry_out;
                    r_flag_zero  <= alu_zero;
                end
            end
        end
    end

    assign cmd_ready  = w_ready;
    assign alu_a      = r_alu_a;
    assign alu_b      = r_alu_b;
    assign alu_carry  = r_alu_carry;
    assign alu_op     = r_alu_op;
    assign res_valid  = r_res_valid;
    assign res_data   = r_res_data;
    assign flag_carry = r_flag_carry;
    assign flag_zero  = r_flag_zero;

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: a behavioural ALU stands in for the
// real one, and a register/flag model predicts every commit.
module tb_alu_sequencer;
    import alu_pkg::*;

    localparam logic [1:0] TB_RESET_FLAGS = 2'b10;

    logic       clk = 1'b0;
    logic       reset;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [3:0] cmd_op;
    logic [1:0] cmd_dst;
    logic [1:0] cmd_srca;
    logic [1:0] cmd_srcb;
    logic       cmd_use_imm;
    logic [7:0] cmd_imm;
    logic       cmd_wreg;
    logic       cmd_wflags;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic       alu_carry;
    logic [3:0] alu_op;
    logic [7:0] alu_c;
    logic       alu_carry_out;
    logic       alu_zero;
    logic       res_valid;
    logic [7:0] res_data;
    logic       flag_carry;
    logic       flag_zero;
    logic [1:0] rd_addr;
    logic [7:0] rd_data;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int acc_cyc  = 0;
    logic [7:0] obs_res;

    logic [7:0] m_regs [4];
    logic       m_carry;
    logic       m_zero;

    always #10 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    alu_sequencer #(
        .NREGS       (4),
        .RESET_FLAGS (TB_RESET_FLAGS)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_op        (cmd_op),
        .cmd_dst       (cmd_dst),
        .cmd_srca      (cmd_srca),
        .cmd_srcb      (cmd_srcb),
        .cmd_use_imm   (cmd_use_imm),
        .cmd_imm       (cmd_imm),
        .cmd_wreg      (cmd_wreg),
        .cmd_wflags    (cmd_wflags),
        .alu_a         (alu_a),
        .alu_b         (alu_b),
        .alu_carry     (alu_carry),
        .alu_op        (alu_op),
        .alu_c         (alu_c),
        .alu_carry_out (alu_carry_out),
        .alu_zero      (alu_zero),
        .res_valid     (res_valid),
        .res_data      (res_data),
        .flag_carry    (flag_carry),
        .flag_zero     (flag_zero),
        .rd_addr       (rd_addr),
        .rd_data       (rd_data)
    );

    // Behavioural ALU: returns {carry_out, zero, result}. Carry on subtraction is a borrow.
    function automatic logic [9:0] alu_ref(input logic [3:0] op, input logic [7:0] a,
                                           input logic [7:0] b, input logic cin);
        int         r;
        logic [7:0] c;
        logic       co;
        r  = 0;
        c  = 8'h00;
        co = 1'b0;
        case (op)
            OP_ADD:   begin r = int'(a) + int'(b);       c = r[7:0]; co = r[8]; end
            OP_ADC:   begin r = int'(a) + int'(b) + int'(cin); c = r[7:0]; co = r[8]; end
            OP_SUB:   begin r = int'(a) - int'(b);       c = r[7:0]; co = (a < b); end
            OP_SBC:   begin r = int'(a) - int'(b) - int'(cin); c = r[7:0]; co = (r < 0); end
            OP_OR:    c = a | b;
            OP_AND:   c = a & b;
            OP_NOT:   c = ~a;
            OP_XOR:   c = a ^ b;
            OP_PASSA: c = a;
            OP_PASSB: c = b;
            OP_NEG:   begin r = 256 - int'(a); c = r[7:0]; co = (a != 8'h00); end
            OP_CMP:   begin c = (a < b) ? 8'hFF : ((a == b) ? 8'h00 : 8'h01); co = (a < b); end
            OP_SHL:   begin r = int'(a) * 2; c = r[7:0]; co = a[7]; end
            OP_SHR:   begin c = a / 8'd2; co = a[0]; end
            default:  c = 8'h00;
        endcase
        return {co, (c == 8'h00), c};
    endfunction

    always_comb begin
        {alu_carry_out, alu_zero, alu_c} = alu_ref(alu_op, alu_a, alu_b, alu_carry);
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_regs[i] = 8'h00;
        {m_carry, m_zero} = TB_RESET_FLAGS;
    endtask

    task automatic check_regs(input string tag);
        for (int i = 0; i < 4; i++) begin
            rd_addr = 2'(i);
            #1;
            check($sformatf("%s_reg%0d", tag, i), {8'h00, rd_data}, {8'h00, m_regs[i]});
        end
    endtask

    // Presents one command, follows it through issue and commit, then updates the model.
    task automatic send(input logic [3:0] op, input logic [1:0] dst, input logic [1:0] srca,
                        input logic [1:0] srcb, input logic use_imm, input logic [7:0] imm,
                        input logic wreg, input logic wflags, input logic hold);
        int         waited;
        logic [7:0] exp_a;
        logic [7:0] exp_b;
        logic       exp_cin;
        logic [9:0] exp_r;
        waited      = 0;
        cmd_op      = op;
        cmd_dst     = dst;
        cmd_srca    = srca;
        cmd_srcb    = srcb;
        cmd_use_imm = use_imm;
        cmd_imm     = imm;
        cmd_wreg    = wreg;
        cmd_wflags  = wflags;
        cmd_valid   = 1'b1;
        @(negedge clk);
        while (!cmd_ready && waited < 8) begin
            @(negedge clk);
            waited++;
        end
        if (!cmd_ready) begin
            check("accept_timeout", {15'h0, cmd_ready}, 16'h1);
            cmd_valid = 1'b0;
            return;
        end
        exp_a   = m_regs[srca];
        exp_b   = use_imm ? imm : m_regs[srcb];
        exp_cin = m_carry;
        exp_r   = alu_ref(op, exp_a, exp_b, exp_cin);
        @(posedge clk);
        #1;
        acc_cyc = cyc;
        if (!hold) cmd_valid = 1'b0;
        check("issue_ready",  {15'h0, cmd_ready}, 16'h0);
        check("issue_rvalid", {15'h0, res_valid}, 16'h0);
        check("issue_alu_a",  {8'h0, alu_a}, {8'h0, exp_a});
        check("issue_alu_b",  {8'h0, alu_b}, {8'h0, exp_b});
        check("issue_alu_op", {12'h0, alu_op}, {12'h0, op});
        check("issue_cin",    {15'h0, alu_carry}, {15'h0, exp_cin});
        @(posedge clk);
        #1;
        check("commit_ready",  {15'h0, cmd_ready}, 16'h0);
        check("commit_rvalid", {15'h0, res_valid}, 16'h0);
        @(posedge clk);
        #1;
        if (wreg) m_regs[dst] = exp_r[7:0];
        if (wflags) {m_carry, m_zero} = exp_r[9:8];
        obs_res = res_data;
        check("res_valid", {15'h0, res_valid}, 16'h1);
        check("res_data",  {8'h0, res_data}, {8'h0, exp_r[7:0]});
        check("flags",     {14'h0, flag_carry, flag_zero}, {14'h0, m_carry, m_zero});
        check_regs("commit");
    endtask

    initial begin
        int acc1;
        reset       = 1'b1;
        cmd_valid   = 1'b0;
        cmd_op      = '0;
        cmd_dst     = '0;
        cmd_srca    = '0;
        cmd_srcb    = '0;
        cmd_use_imm = 1'b0;
        cmd_imm     = '0;
        cmd_wreg    = 1'b0;
        cmd_wflags  = 1'b0;
        rd_addr     = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        check("rst_ready",  {15'h0, cmd_ready}, 16'h1);
        check("rst_rvalid", {15'h0, res_valid}, 16'h0);
        check("rst_rdata",  {8'h0, res_data}, 16'h0);
        check("rst_flags",  {14'h0, flag_carry, flag_zero}, {14'h0, TB_RESET_FLAGS});
        check("rst_alu",    {alu_a, alu_b}, 16'h0);
        check("rst_aluop",  {11'h0, alu_carry, alu_op}, 16'h0);
        check_regs("rst");

        // Load immediate through PASSB.
        send(OP_PASSB, 2'd1, 2'd0, 2'd0, 1'b1, 8'h7F, 1'b1, 1'b1, 1'b0);
        check("pb_res",   {8'h0, obs_res}, 16'h007F);
        check("pb_flags", {14'h0, flag_carry, flag_zero}, 16'h0);

        // ADD overflowing to zero, then ADC consuming the carry.
        send(OP_PASSB, 2'd1, 2'd0, 2'd0, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0);
        send(OP_PASSB, 2'd2, 2'd0, 2'd0, 1'b1, 8'h01, 1'b1, 1'b0, 1'b0);
        send(OP_ADD,   2'd3, 2'd1, 2'd2, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
        check("add_res",   {8'h0, obs_res}, 16'h0000);
        check("add_flags", {14'h0, flag_carry, flag_zero}, 16'h0003);
        send(OP_ADC,   2'd0, 2'd2, 2'd2, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
        check("adc_res",   {8'h0, obs_res}, 16'h0003);

        // Compare form: flags only.
        send(OP_PASSB, 2'd0, 2'd0, 2'd0, 1'b1, 8'h05, 1'b1, 1'b0, 1'b0);
        send(OP_CMP,   2'd0, 2'd0, 2'd0, 1'b1, 8'h09, 1'b0, 1'b1, 1'b0);
        check("cmp_lt_res",   {8'h0, obs_res}, 16'h00FF);
        check("cmp_lt_flags", {14'h0, flag_carry, flag_zero}, 16'h0002);
        send(OP_CMP,   2'd0, 2'd0, 2'd0, 1'b1, 8'h05, 1'b0, 1'b1, 1'b0);
        check("cmp_eq_res",   {8'h0, obs_res}, 16'h0000);
        check("cmp_eq_zero",  {15'h0, flag_zero}, 16'h0001);

        // Back-to-back with cmd_valid held; second reads the first's result.
        send(OP_PASSB, 2'd2, 2'd0, 2'd0, 1'b1, 8'h3C, 1'b1, 1'b0, 1'b1);
        acc1 = acc_cyc;
        send(OP_ADD,   2'd3, 2'd2, 2'd2, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        check("b2b_spacing", 16'(acc_cyc - acc1), 16'd3);
        check("b2b_res",     {8'h0, obs_res}, 16'h0078);

        // wflags=0 leaves flags alone.
        send(OP_PASSB, 2'd0, 2'd0, 2'd0, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0);
        send(OP_ADD,   2'd0, 2'd0, 2'd0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
        send(OP_XOR,   2'd1, 2'd0, 2'd0, 1'b1, 8'hFE, 1'b1, 1'b0, 1'b0);
        check("nowf_res",   {8'h0, obs_res}, 16'h0000);
        check("nowf_flags", {14'h0, flag_carry, flag_zero}, 16'h0002);

        // Reset during ISSUE drops the in-flight SHL.
        send(OP_PASSB, 2'd0, 2'd0, 2'd0, 1'b1, 8'h81, 1'b1, 1'b0, 1'b0);
        cmd_op = OP_SHL; cmd_dst = 2'd0; cmd_srca = 2'd0; cmd_use_imm = 1'b0;
        cmd_wreg = 1'b1; cmd_wflags = 1'b1; cmd_valid = 1'b1;
        @(negedge clk);
        check("rsti_ready", {15'h0, cmd_ready}, 16'h1);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        reset     = 1'b1;
        check("rsti_alu_a", {8'h0, alu_a}, 16'h0081);
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        check("rsti_rvalid", {15'h0, res_valid}, 16'h0);
        check("rsti_ready2", {15'h0, cmd_ready}, 16'h1);
        check("rsti_flags",  {14'h0, flag_carry, flag_zero}, {14'h0, TB_RESET_FLAGS});
        check_regs("rsti");
        @(posedge clk);
        #1;
        check("rsti_rvalid2", {15'h0, res_valid}, 16'h0);

        // Randomized commands against the model.
        for (int n = 0; n < 60; n++) begin
            send(4'($urandom_range(0, 13)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
